// File: rtl/port_e_pkg.sv
// port_e_pkg: shared constants and types for the port E I/O block.
//   - I/O addresses of PINE / DDRE / PORTE
//   - pin index constants PE0..PE3
//   - override pair / per-pin override bundle structs
package port_e_pkg;

  localparam int NUM_PINS = 4;

  localparam logic [5:0] PINE_ADDR  = 6'h0C;
  localparam logic [5:0] DDRE_ADDR  = 6'h0D;
  localparam logic [5:0] PORTE_ADDR = 6'h0E;

  localparam int PE0 = 0;
  localparam int PE1 = 1;
  localparam int PE2 = 2;
  localparam int PE3 = 3;

  // One override: when oe is set, ov replaces the default value.
  typedef struct packed {
    logic oe;
    logic ov;
  } ovr_t;

  // Complete override set for one pin.
  typedef struct packed {
    ovr_t pu;
    ovr_t dd;
    ovr_t pv;
    ovr_t die;
  } pin_ovr_t;

endpackage

// File: rtl/port_e_pin_ovr.sv
// port_e_pin_ovr: per-pin default/override mux.
//   i_ddr, i_port : DDRE / PORTE bit for this pin
//   i_pud, i_sleep: global pull-up disable / sleep
//   i_ovr         : alternate-function overrides for this pin
//   o_pu, o_dd, o_pv, o_die : final pull-up, direction, value, input enable
module port_e_pin_ovr
  import port_e_pkg::*;
(
  input  logic     i_ddr,
  input  logic     i_port,
  input  logic     i_pud,
  input  logic     i_sleep,
  input  pin_ovr_t i_ovr,
  output logic     o_pu,
  output logic     o_dd,
  output logic     o_pv,
  output logic     o_die
);

  logic w_pu_def;
  assign w_pu_def = ~i_ddr & i_port & ~i_pud;

  assign o_pu  = i_ovr.pu.oe  ? i_ovr.pu.ov  : w_pu_def;
  assign o_dd  = i_ovr.dd.oe  ? i_ovr.dd.ov  : i_ddr;
  assign o_pv  = i_ovr.pv.oe  ? i_ovr.pv.ov  : i_port;
  assign o_die = i_ovr.die.oe ? i_ovr.die.ov : ~i_sleep;

endmodule

// File: rtl/port_e.sv
// port_e: 4-pin general purpose I/O port E with alternate-function overrides.
//   cp2/ireset            : clock, async active-low reset
//   IO_Addr/iore/iowe     : I/O bus address and strobes
//   dbus_in/dbus_out/out_en: write data, read data, read-data valid
//   pinE_i / DIE_o        : pad inputs / input-enable gated pad inputs
//   pu_E/dd_E/pv_E/die_E  : final per-pin pad controls
//   remaining inputs      : alternate-function (TWI1, SPI1, ACO, PCINT, ADC) controls
module port_e
  import port_e_pkg::*;
(
  input  logic                cp2,
  input  logic                ireset,
  input  logic [5:0]          IO_Addr,
  input  logic                iore,
  input  logic                iowe,
  input  logic [7:0]          dbus_in,
  output logic [7:0]          dbus_out,
  output logic                out_en,
  input  logic [NUM_PINS-1:0] pinE_i,
  output logic [NUM_PINS-1:0] DIE_o,
  output logic [NUM_PINS-1:0] pu_E,
  output logic [NUM_PINS-1:0] dd_E,
  output logic [NUM_PINS-1:0] pv_E,
  output logic [NUM_PINS-1:0] die_E,
  input  logic                PUD,
  input  logic                SLEEP,
  input  logic                RSTDISBL,
  input  logic                TWEN1,
  input  logic                SPE1,
  input  logic                MSTR,
  input  logic                SCK1_OUT,
  input  logic                SPI1_MT_OUT,
  input  logic                SCL1_OUT,
  input  logic                SDA1_OUT,
  input  logic                PCIE3,
  input  logic                aco_oe,
  input  logic                acompout,
  input  logic [1:0]          ADCxD,
  input  logic [NUM_PINS-1:0] PCINT
);

  logic [NUM_PINS-1:0] r_ddre, r_porte;
  logic [NUM_PINS-1:0] r_sync1, r_sync2;
  pin_ovr_t [NUM_PINS-1:0] w_ovr;
  logic w_spi_slv, w_spi_mst, w_pe0_oe;
  logic w_unused;

  // Inputs present for interface compatibility only.
  assign w_unused = ^{RSTDISBL, SCK1_OUT, dbus_in[7:4]};

  // Register writes; writing PINE toggles PORTE bits.
  always_ff @(posedge cp2 or negedge ireset) begin
    if (!ireset) begin
      r_ddre  <= '0;
      r_porte <= '0;
    end else if (iowe) begin
      case (IO_Addr)
        DDRE_ADDR:  r_ddre  <= dbus_in[NUM_PINS-1:0];
        PORTE_ADDR: r_porte <= dbus_in[NUM_PINS-1:0];
        PINE_ADDR:  r_porte <= r_porte ^ dbus_in[NUM_PINS-1:0];
        default: ;
      endcase
    end
  end

  // Two-flop synchronizer on the gated pad inputs.
  always_ff @(posedge cp2 or negedge ireset) begin
    if (!ireset) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= DIE_o;
      r_sync2 <= r_sync1;
    end
  end

  assign DIE_o = pinE_i & die_E;

  // Reads see register contents before any same-cycle write.
  always_comb begin
    out_en   = 1'b0;
    dbus_out = '0;
    if (iore) begin
      case (IO_Addr)
        PINE_ADDR:  begin out_en = 1'b1; dbus_out = {4'b0000, r_sync2}; end
        DDRE_ADDR:  begin out_en = 1'b1; dbus_out = {4'b0000, r_ddre};  end
        PORTE_ADDR: begin out_en = 1'b1; dbus_out = {4'b0000, r_porte}; end
        default: ;
      endcase
    end
  end

  assign w_spi_slv = SPE1 & ~MSTR;
  assign w_spi_mst = SPE1 & MSTR;
  assign w_pe0_oe  = TWEN1 | aco_oe;

  // Alternate-function override table.
  always_comb begin
    w_ovr = '0;
    // PE3: SPI1 data pin, PCINT27 / ADC7
    w_ovr[PE3].pu  = '{oe: w_spi_slv, ov: r_porte[PE3] & ~PUD};
    w_ovr[PE3].dd  = '{oe: w_spi_slv, ov: 1'b0};
    w_ovr[PE3].pv  = '{oe: w_spi_mst, ov: SPI1_MT_OUT};
    w_ovr[PE3].die = '{oe: (PCINT[PE3] & PCIE3) | ADCxD[1], ov: PCINT[PE3] & PCIE3};
    // PE2: SPI1 slave select, PCINT26 / ADC6
    w_ovr[PE2].pu  = '{oe: w_spi_slv, ov: r_porte[PE2] & ~PUD};
    w_ovr[PE2].dd  = '{oe: w_spi_slv, ov: 1'b0};
    w_ovr[PE2].pv  = '{oe: 1'b0, ov: 1'b0};
    w_ovr[PE2].die = '{oe: (PCINT[PE2] & PCIE3) | ADCxD[0], ov: PCINT[PE2] & PCIE3};
    // PE1: TWI1 clock
    w_ovr[PE1].pu  = '{oe: TWEN1, ov: r_porte[PE1] & ~PUD};
    w_ovr[PE1].dd  = '{oe: TWEN1, ov: 1'b1};
    w_ovr[PE1].pv  = '{oe: TWEN1, ov: SCL1_OUT};
    w_ovr[PE1].die = '{oe: PCINT[PE1] & PCIE3, ov: 1'b1};
    // PE0: TWI1 data or analog comparator output
    w_ovr[PE0].pu  = '{oe: w_pe0_oe, ov: r_porte[PE0] & ~PUD};
    w_ovr[PE0].dd  = '{oe: w_pe0_oe, ov: 1'b1};
    w_ovr[PE0].pv  = '{oe: w_pe0_oe, ov: (aco_oe & acompout) | (TWEN1 & SDA1_OUT)};
    w_ovr[PE0].die = '{oe: PCINT[PE0] & PCIE3, ov: 1'b1};
  end

  for (genvar n = 0; n < NUM_PINS; n++) begin : g_pin
    port_e_pin_ovr u_pin (
      .i_ddr   (r_ddre[n]),
      .i_port  (r_porte[n]),
      .i_pud   (PUD),
      .i_sleep (SLEEP),
      .i_ovr   (w_ovr[n]),
      .o_pu    (pu_E[n]),
      .o_dd    (dd_E[n]),
      .o_pv    (pv_E[n]),
      .o_die   (die_E[n])
    );
  end

endmodule

// File: tb/tb_port_e.sv
module tb_port_e;

  logic       cp2 = 1'b0;
  logic       ireset;
  logic [5:0] IO_Addr;
  logic       iore, iowe;
  logic [7:0] dbus_in, dbus_out;
  logic       out_en;
  logic [3:0] pinE_i, DIE_o, pu_E, dd_E, pv_E, die_E;
  logic PUD, SLEEP, RSTDISBL, TWEN1, SPE1, MSTR, SCK1_OUT, SPI1_MT_OUT;
  logic SCL1_OUT, SDA1_OUT, PCIE3, aco_oe, acompout;
  logic [1:0] ADCxD;
  logic [3:0] PCINT;

  int errors = 0;
  int checks = 0;

  // reference state
  logic [3:0] m_ddr, m_port, m_s1, m_s2;

  always #5 cp2 = ~cp2;

  port_e dut (
    .cp2(cp2), .ireset(ireset), .IO_Addr(IO_Addr), .iore(iore), .iowe(iowe),
    .dbus_in(dbus_in), .dbus_out(dbus_out), .out_en(out_en),
    .pinE_i(pinE_i), .DIE_o(DIE_o), .pu_E(pu_E), .dd_E(dd_E), .pv_E(pv_E), .die_E(die_E),
    .PUD(PUD), .SLEEP(SLEEP), .RSTDISBL(RSTDISBL), .TWEN1(TWEN1), .SPE1(SPE1), .MSTR(MSTR),
    .SCK1_OUT(SCK1_OUT), .SPI1_MT_OUT(SPI1_MT_OUT), .SCL1_OUT(SCL1_OUT), .SDA1_OUT(SDA1_OUT),
    .PCIE3(PCIE3), .aco_oe(aco_oe), .acompout(acompout), .ADCxD(ADCxD), .PCINT(PCINT)
  );

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Pin behaviour straight from the pin function table.
  task automatic model_pins(output logic [3:0] pu, output logic [3:0] dd,
                            output logic [3:0] pv, output logic [3:0] die);
    for (int n = 0; n < 4; n++) begin
      logic p_pu, p_dd, p_pv, p_die, pc;
      p_pu  = !m_ddr[n] && m_port[n] && !PUD;
      p_dd  = m_ddr[n];
      p_pv  = m_port[n];
      p_die = !SLEEP;
      pc    = PCINT[n] && PCIE3;
      if (n >= 2) begin
        if (SPE1 && !MSTR) begin p_pu = m_port[n] && !PUD; p_dd = 1'b0; end
        if (n == 3 && SPE1 && MSTR) p_pv = SPI1_MT_OUT;
        if (pc || ADCxD[n-2]) p_die = pc;
      end else if (n == 1) begin
        if (TWEN1) begin p_pu = m_port[n] && !PUD; p_dd = 1'b1; p_pv = SCL1_OUT; end
        if (pc) p_die = 1'b1;
      end else begin
        if (TWEN1 || aco_oe) begin
          p_pu = m_port[n] && !PUD; p_dd = 1'b1;
          p_pv = (aco_oe && acompout) || (TWEN1 && SDA1_OUT);
        end
        if (pc) p_die = 1'b1;
      end
      pu[n] = p_pu; dd[n] = p_dd; pv[n] = p_pv; die[n] = p_die;
    end
  endtask

  task automatic check_all(input string tag);
    logic [3:0] epu, edd, epv, edie;
    logic [7:0] erd;
    logic       een;
    model_pins(epu, edd, epv, edie);
    check({tag, ".pu"},  {4'h0, pu_E},  {4'h0, epu});
    check({tag, ".dd"},  {4'h0, dd_E},  {4'h0, edd});
    check({tag, ".pv"},  {4'h0, pv_E},  {4'h0, epv});
    check({tag, ".die"}, {4'h0, die_E}, {4'h0, edie});
    check({tag, ".DIE_o"}, {4'h0, DIE_o}, {4'h0, pinE_i & edie});
    een = 1'b0; erd = 8'h00;
    if (iore && IO_Addr == 6'h0C) begin een = 1'b1; erd = {4'h0, m_s2};   end
    if (iore && IO_Addr == 6'h0D) begin een = 1'b1; erd = {4'h0, m_ddr};  end
    if (iore && IO_Addr == 6'h0E) begin een = 1'b1; erd = {4'h0, m_port}; end
    check({tag, ".out_en"}, {7'h0, out_en}, {7'h0, een});
    check({tag, ".dbus_out"}, dbus_out, erd);
  endtask

  // One clock edge; the model advances with the same inputs the DUT saw.
  task automatic tick();
    logic [3:0] epu, edd, epv, edie, din;
    model_pins(epu, edd, epv, edie);
    din = pinE_i & edie;
    @(posedge cp2);
    if (!ireset) begin
      m_ddr = '0; m_port = '0; m_s1 = '0; m_s2 = '0;
    end else begin
      if (iowe && IO_Addr == 6'h0D) m_ddr = dbus_in[3:0];
      if (iowe && IO_Addr == 6'h0E) m_port = dbus_in[3:0];
      if (iowe && IO_Addr == 6'h0C) m_port = m_port ^ dbus_in[3:0];
      m_s2 = m_s1;
      m_s1 = din;
    end
    #1;
  endtask

  task automatic wr(input logic [5:0] a, input logic [7:0] d);
    IO_Addr = a; dbus_in = d; iowe = 1'b1;
    tick();
    iowe = 1'b0;
  endtask

  task automatic rd(input logic [5:0] a);
    IO_Addr = a; iore = 1'b1; #1;
  endtask

  task automatic no_ovr();
    TWEN1 = 0; SPE1 = 0; MSTR = 0; aco_oe = 0; acompout = 0; PCIE3 = 0;
    PCINT = 0; ADCxD = 0; SPI1_MT_OUT = 0; SCL1_OUT = 0; SDA1_OUT = 0;
  endtask

  initial begin
    m_ddr = '0; m_port = '0; m_s1 = '0; m_s2 = '0;
    ireset = 0; IO_Addr = 0; iore = 0; iowe = 0; dbus_in = 0; pinE_i = 0;
    PUD = 0; SLEEP = 0; RSTDISBL = 0; SCK1_OUT = 0;
    no_ovr();

    // reset state, with a write attempted during reset
    IO_Addr = 6'h0D; dbus_in = 8'hFF; iowe = 1;
    tick(); tick();
    iowe = 0;
    check("rst.pu", {4'h0, pu_E}, 8'h00);
    check("rst.dd", {4'h0, dd_E}, 8'h00);
    check("rst.pv", {4'h0, pv_E}, 8'h00);
    check("rst.die", {4'h0, die_E}, 8'h0F);
    check("rst.out_en", {7'h0, out_en}, 8'h00);
    check("rst.dbus_out", dbus_out, 8'h00);
    ireset = 1; tick();
    rd(6'h0D); check("rst.ddre_rd", dbus_out, 8'h00);
    rd(6'h0E); check("rst.porte_rd", dbus_out, 8'h00);
    iore = 0;

    // pull-up default and PUD
    wr(6'h0D, 8'h00); wr(6'h0E, 8'hFF);
    check("pud0.pu", {4'h0, pu_E}, 8'h0F);
    check("pud0.dd", {4'h0, dd_E}, 8'h00);
    PUD = 1; #1; check("pud1.pu", {4'h0, pu_E}, 8'h00);
    PUD = 0;

    // PINE write toggles PORTE
    wr(6'h0D, 8'hFF); wr(6'h0E, 8'h00); wr(6'h0C, 8'h03);
    check("tog1.pv", {4'h0, pv_E}, 8'h03);
    wr(6'h0E, 8'hFF); wr(6'h0C, 8'h0C);
    check("tog2.pv", {4'h0, pv_E}, 8'h03);
    rd(6'h0E);
    check("tog.rd", dbus_out, 8'h03);
    check("tog.out_en", {7'h0, out_en}, 8'h01);
    rd(6'h0D); check("ddre.rd", dbus_out, 8'h0F);
    // simultaneous read/write returns the old value; upper data bits ignored
    rd(6'h0E); iowe = 1; dbus_in = 8'hA9; #1;
    check("rdwr.pre", dbus_out, 8'h03);
    tick(); iowe = 0;
    check("rdwr.post", dbus_out, 8'h09);
    iore = 0; #1;
    check("idle.out_en", {7'h0, out_en}, 8'h00);
    check("idle.dbus", dbus_out, 8'h00);

    // TWI / SPI slave overrides on pull-up and direction
    wr(6'h0D, 8'h00); wr(6'h0E, 8'h0F);
    TWEN1 = 1; SPE1 = 1; MSTR = 0; #1;
    check("ovr.pu", {4'h0, pu_E}, 8'h0F);
    check("ovr.dd", {4'h0, dd_E}, 8'h03);
    wr(6'h0E, 8'h00);
    check("ovr.pu0", {4'h0, pu_E}, 8'h00);

    // output value overrides
    SPE1 = 1; MSTR = 1; TWEN1 = 1; aco_oe = 1;
    SPI1_MT_OUT = 0; SCL1_OUT = 0; SDA1_OUT = 0; acompout = 0;
    wr(6'h0D, 8'h0F); wr(6'h0E, 8'h0F);
    check("pvovr0", {4'h0, pv_E}, 8'h04);
    SPI1_MT_OUT = 1; SCL1_OUT = 1; SDA1_OUT = 1;
    wr(6'h0E, 8'h00);
    check("pvovr1", {4'h0, pv_E}, 8'h0B);
    no_ovr();

    // digital input enable overrides
    PCINT = 4'h3; PCIE3 = 1; ADCxD = 2'b11; SLEEP = 0; #1;
    check("die.s0", {4'h0, die_E}, 8'h03);
    SLEEP = 1; #1; check("die.s1", {4'h0, die_E}, 8'h03);
    PCINT = 4'hF; ADCxD = 0; #1; check("die.pcall", {4'h0, die_E}, 8'h0F);
    no_ovr(); #1; check("die.sleep", {4'h0, die_E}, 8'h00);
    SLEEP = 0;

    // input path: combinational DIE_o, two-edge PINE latency
    pinE_i = 4'hA; #1;
    check("die_o", {4'h0, DIE_o}, 8'h0A);
    tick(); tick();
    rd(6'h0C); check("pine.2cyc", dbus_out, 8'h0A);
    check_all("pine.model");
    iore = 0;

    // randomized traffic against the model
    for (int i = 0; i < 300; i++) begin
      PUD = $urandom_range(0, 3) == 0; SLEEP = $urandom_range(0, 3) == 0;
      TWEN1 = $urandom_range(0, 3) == 0; SPE1 = $urandom_range(0, 3) == 0;
      MSTR = $urandom_range(0, 1); aco_oe = $urandom_range(0, 3) == 0;
      acompout = $urandom_range(0, 1); SPI1_MT_OUT = $urandom_range(0, 1);
      SCL1_OUT = $urandom_range(0, 1); SDA1_OUT = $urandom_range(0, 1);
      SCK1_OUT = $urandom_range(0, 1); RSTDISBL = $urandom_range(0, 1);
      PCIE3 = $urandom_range(0, 1); PCINT = 4'($urandom);
      ADCxD = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b00;
      pinE_i = 4'($urandom); dbus_in = 8'($urandom);
      case ($urandom_range(0, 3))
        0: IO_Addr = 6'h0C;
        1: IO_Addr = 6'h0D;
        2: IO_Addr = 6'h0E;
        default: IO_Addr = 6'($urandom);
      endcase
      iowe = $urandom_range(0, 1); iore = $urandom_range(0, 1);
      #1; check_all("rand");
      tick();
    end
    iowe = 0; iore = 0;

    // asynchronous reset clears everything mid-cycle
    #2 ireset = 0; #1;
    m_ddr = '0; m_port = '0; m_s1 = '0; m_s2 = '0;
    no_ovr(); PUD = 0; SLEEP = 0;
    rd(6'h0D); check("arst.ddre", dbus_out, 8'h00);
    rd(6'h0C); check("arst.pine", dbus_out, 8'h00);
    check_all("arst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
